// File: rtl/axi_stream_sideband_crc_strip.sv
// Receive-side CRC trailer strip: removes the final 4 bytes of each AXI-Stream packet
// and presents them on a sideband port, holding one beat back for straddling trailers.
module axi_stream_sideband_crc_strip #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_BYTES = DATA_WIDTH / 8,
    parameter int CRC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_s_tdata,
    input  logic [KEEP_BYTES-1:0] i_s_tkeep,
    input  logic                  i_s_tlast,
    input  logic                  i_s_tvalid,
    output logic                  o_s_tready,
    output logic [DATA_WIDTH-1:0] o_m_tdata,
    output logic [KEEP_BYTES-1:0] o_m_tkeep,
    output logic                  o_m_tlast,
    output logic                  o_m_tvalid,
    input  logic                  i_m_tready,
    output logic [CRC_WIDTH-1:0]  o_crc,
    output logic                  o_crc_valid,
    output logic                  o_runt,
    output logic [1:0]            o_state
);

    // Handshakes: a beat moves on a port in the cycle where its tvalid and tready are
    // both high at the rising edge; a held-off master keeps tdata/tkeep/tlast stable.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   h_data_q, h_data_d;
    logic [KEEP_BYTES-1:0]   h_keep_q, h_keep_d;
    logic                    h_last_q, h_last_d;

    logic [DATA_WIDTH-1:0]   m_data_d;
    logic [KEEP_BYTES-1:0]   m_keep_d;
    logic                    m_last_d;
    logic                    m_valid_d;
    logic [CRC_WIDTH-1:0]    crc_d;
    logic                    crc_valid_d;
    logic                    runt_d;

    logic                    out_free;
    int                      n_bytes;
    logic [2*DATA_WIDTH-1:0] cat;
    logic [CRC_WIDTH-1:0]    crc_pick;
    logic [KEEP_BYTES-1:0]   keep_new_mask;
    logic [KEEP_BYTES-1:0]   keep_h_mask;

    assign out_free = !o_m_tvalid || i_m_tready;
    assign o_state  = state_q;

    // The trailer always sits at byte offset KEEP_BYTES+n-4 of {new beat, held beat},
    // which covers both the in-beat and the straddling case with one selector.
    always_comb begin
        n_bytes = 0;
        for (int b = 0; b < KEEP_BYTES; b++) begin
            if (i_s_tkeep[b]) n_bytes++;
        end
        cat      = {i_s_tdata, h_data_q};
        crc_pick = CRC_WIDTH'(cat >> (8 * (KEEP_BYTES + n_bytes - 4)));
        for (int b = 0; b < KEEP_BYTES; b++) begin
            keep_new_mask[b] = (b + 4 < n_bytes);
            keep_h_mask[b]   = (b + 4 < KEEP_BYTES + n_bytes);
        end
    end

    always_comb begin
        state_d     = state_q;
        h_data_d    = h_data_q;
        h_keep_d    = h_keep_q;
        h_last_d    = h_last_q;
        m_data_d    = o_m_tdata;
        m_keep_d    = o_m_tkeep;
        m_last_d    = o_m_tlast;
        m_valid_d   = out_free ? 1'b0 : o_m_tvalid;
        crc_d       = o_crc;
        crc_valid_d = 1'b0;
        runt_d      = 1'b0;
        o_s_tready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_s_tready = rst_n;
                if (i_s_tvalid) begin
                    if (!i_s_tlast) begin
                        h_data_d = i_s_tdata;
                        h_keep_d = i_s_tkeep;
                        h_last_d = 1'b0;
                        state_d  = S_HOLD;
                    end else if (n_bytes > 4) begin
                        h_data_d    = i_s_tdata;
                        h_keep_d    = i_s_tkeep & keep_new_mask;
                        h_last_d    = 1'b1;
                        crc_d       = crc_pick;
                        crc_valid_d = 1'b1;
                        state_d     = S_TAIL;
                    end else begin
                        runt_d = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                o_s_tready = out_free && rst_n;
                if (i_s_tvalid && out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = h_data_q;
                    m_keep_d  = h_keep_q;
                    m_last_d  = 1'b0;
                    if (!i_s_tlast) begin
                        h_data_d = i_s_tdata;
                        h_keep_d = i_s_tkeep;
                        h_last_d = 1'b0;
                    end else begin
                        crc_d       = crc_pick;
                        crc_valid_d = 1'b1;
                        if (n_bytes > 4) begin
                            h_data_d = i_s_tdata;
                            h_keep_d = i_s_tkeep & keep_new_mask;
                            h_last_d = 1'b1;
                            state_d  = S_TAIL;
                        end else begin
                            // Part (or none) of the trailer lives in the held beat: trim it.
                            m_keep_d = h_keep_q & keep_h_mask;
                            m_last_d = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                end
            end

            S_TAIL: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = h_data_q;
                    m_keep_d  = h_keep_q;
                    m_last_d  = h_last_q;
                    state_d   = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            h_data_q    <= '0;
            h_keep_q    <= '0;
            h_last_q    <= 1'b0;
            o_m_tdata   <= '0;
            o_m_tkeep   <= '0;
            o_m_tlast   <= 1'b0;
            o_m_tvalid  <= 1'b0;
            o_crc       <= '0;
            o_crc_valid <= 1'b0;
            o_runt      <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_data_q    <= h_data_d;
            h_keep_q    <= h_keep_d;
            h_last_q    <= h_last_d;
            o_m_tdata   <= m_data_d;
            o_m_tkeep   <= m_keep_d;
            o_m_tlast   <= m_last_d;
            o_m_tvalid  <= m_valid_d;
            o_crc       <= crc_d;
            o_crc_valid <= crc_valid_d;
            o_runt      <= runt_d;
        end
    end

endmodule

// File: tb/tb_axi_stream_sideband_crc_strip.sv
// Bench for axi_stream_sideband_crc_strip at DATA_WIDTH=64: byte-level packet model,
// per-cycle output compare, and literal expectations for the directed scenarios.
module tb_axi_stream_sideband_crc_strip;

  localparam int DW = 64;
  localparam int KB = DW / 8;
  localparam int EW = 1 + KB + DW;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] i_s_tdata;
  logic [KB-1:0] i_s_tkeep;
  logic          i_s_tlast;
  logic          i_s_tvalid;
  logic          o_s_tready;
  logic [DW-1:0] o_m_tdata;
  logic [KB-1:0] o_m_tkeep;
  logic          o_m_tlast;
  logic          o_m_tvalid;
  logic          i_m_tready;
  logic [31:0]   o_crc;
  logic          o_crc_valid;
  logic          o_runt;
  logic [1:0]    o_state;

  axi_stream_sideband_crc_strip #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_s_tdata(i_s_tdata), .i_s_tkeep(i_s_tkeep), .i_s_tlast(i_s_tlast),
    .i_s_tvalid(i_s_tvalid), .o_s_tready(o_s_tready),
    .o_m_tdata(o_m_tdata), .o_m_tkeep(o_m_tkeep), .o_m_tlast(o_m_tlast),
    .o_m_tvalid(o_m_tvalid), .i_m_tready(i_m_tready),
    .o_crc(o_crc), .o_crc_valid(o_crc_valid), .o_runt(o_runt), .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   crc_q[$];
  int            runt_exp = 0;

  logic [DW-1:0] last_data;
  logic [KB-1:0] last_keep;
  logic          last_last;
  logic [31:0]   last_crc;
  int            crc_pulses = 0;
  int            runt_pulses = 0;
  int            out_beats = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] keep_mask(input logic [KB-1:0] k);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < KB; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Model: the output is the packet minus its last 4 bytes, re-cut into full beats.
  task automatic model_packet(input int len, input logic [7:0] base);
    int            payload;
    int            cnt;
    logic [DW-1:0] d;
    logic [KB-1:0] k;
    logic [31:0]   c;
    if (len <= 4) begin
      runt_exp++;
      return;
    end
    payload = len - 4;
    for (int i = 0; i < 4; i++) c[8*i +: 8] = 8'(int'(base) + len - 4 + i);
    crc_q.push_back(c);
    for (int off = 0; off < payload; off += KB) begin
      cnt = (payload - off < KB) ? payload - off : KB;
      d = '0;
      k = '0;
      for (int i = 0; i < cnt; i++) begin
        d[8*i +: 8] = 8'(int'(base) + off + i);
        k[i] = 1'b1;
      end
      exp_q.push_back({(off + KB >= payload), k, d});
    end
  endtask

  // driver tasks
  task automatic drive_beat(input logic [DW-1:0] d, input logic [KB-1:0] k, input logic l);
    logic hs;
    int   budget;
    i_s_tdata  = d;
    i_s_tkeep  = k;
    i_s_tlast  = l;
    i_s_tvalid = 1'b1;
    budget = 0;
    hs = 1'b0;
    while (!hs && budget < 200) begin
      @(negedge clk);
      hs = o_s_tready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: actual=no_accept expected=accept");
    end
  endtask

  task automatic send_pkt(input int len, input logic [7:0] base);
    int            nbeats;
    int            idx;
    logic [DW-1:0] d;
    logic [KB-1:0] k;
    model_packet(len, base);
    nbeats = (len + KB - 1) / KB;
    for (int j = 0; j < nbeats; j++) begin
      d = '0;
      k = '0;
      for (int i = 0; i < KB; i++) begin
        idx = j * KB + i;
        if (idx < len) begin
          d[8*i +: 8] = 8'(int'(base) + idx);
          k[i] = 1'b1;
        end
      end
      drive_beat(d, k, (j == nbeats - 1));
    end
    i_s_tvalid = 1'b0;
    i_s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int b;
    b = 0;
    while ((exp_q.size() != 0 || crc_q.size() != 0 || runt_exp != 0) && b < 300) begin
      @(negedge clk);
      b++;
    end
    chk({nm, "_drain"}, (b < 300), 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // scoreboard / compare process
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_beat;
  logic [EW-1:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && o_m_tvalid)
        chk("stall_stable", {o_m_tlast, o_m_tkeep, o_m_tdata}, prev_beat);
      if (o_m_tvalid && i_m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", {o_m_tlast, o_m_tkeep, o_m_tdata & keep_mask(o_m_tkeep)}, e);
        end
        last_data = o_m_tdata;
        last_keep = o_m_tkeep;
        last_last = o_m_tlast;
        out_beats++;
      end
      prev_stall = o_m_tvalid && !i_m_tready;
      prev_beat  = {o_m_tlast, o_m_tkeep, o_m_tdata};
      if (o_crc_valid) begin
        crc_pulses++;
        last_crc = o_crc;
        if (crc_q.size() == 0) chk("unexpected_crc", 1'b1, 1'b0);
        else chk("crc", o_crc, crc_q.pop_front());
      end
      if (o_runt) begin
        runt_pulses++;
        chk("runt_expected", (runt_exp > 0), 1'b1);
        if (runt_exp > 0) runt_exp--;
      end
    end
  end

  int            c0;
  int            r0;
  int            b0;
  int            tbl[6] = '{5, 16, 11, 1, 23, 8};

  initial begin
    rst_n      = 1'b0;
    i_s_tdata  = '0;
    i_s_tkeep  = '0;
    i_s_tlast  = 1'b0;
    i_s_tvalid = 1'b0;
    i_m_tready = 1'b1;
    #3;
    chk("rst_m_tvalid", o_m_tvalid, 1'b0);
    chk("rst_m_tdata", o_m_tdata, '0);
    chk("rst_m_tkeep", o_m_tkeep, '0);
    chk("rst_m_tlast", o_m_tlast, 1'b0);
    chk("rst_crc", o_crc, '0);
    chk("rst_crc_valid", o_crc_valid, 1'b0);
    chk("rst_runt", o_runt, 1'b0);
    chk("rst_s_tready", o_s_tready, 1'b0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_s_tready", o_s_tready, 1'b1);

    // 1: single full beat
    c0 = crc_pulses; b0 = out_beats;
    send_pkt(8, 8'h00);
    wait_drain("t1");
    chk("t1_keep", last_keep, 8'h0F);
    chk("t1_data", last_data[31:0], 32'h03020100);
    chk("t1_last", last_last, 1'b1);
    chk("t1_crc", last_crc, 32'h07060504);
    chk("t1_crc_pulses", crc_pulses - c0, 1);
    chk("t1_beats", out_beats - b0, 1);

    // 2: trailer straddles, n=2
    send_pkt(10, 8'h00);
    wait_drain("t2");
    chk("t2_keep", last_keep, 8'h3F);
    chk("t2_last", last_last, 1'b1);
    chk("t2_crc", last_crc, 32'h09080706);

    // 3: trailer is exactly the second beat
    b0 = out_beats;
    send_pkt(12, 8'h10);
    wait_drain("t3");
    chk("t3_keep", last_keep, 8'hFF);
    chk("t3_data", last_data, 64'h1716151413121110);
    chk("t3_crc", last_crc, 32'h1B1A1918);
    chk("t3_beats", out_beats - b0, 1);

    // 4: three beats with sink backpressure after first output
    fork
      send_pkt(22, 8'h40);
      begin : stall
        int w;
        w = 0;
        do begin
          @(posedge clk);
          #1;
          w++;
        end while (!o_m_tvalid && w < 100);
        chk("t4_first_out", o_m_tvalid, 1'b1);
        i_m_tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("t4_s_tready_low", o_s_tready, 1'b0);
        end
        @(posedge clk);
        #1;
        i_m_tready = 1'b1;
      end
    join
    wait_drain("t4");
    chk("t4_keep", last_keep, 8'h03);
    chk("t4_data", last_data[15:0], 16'h5150);
    chk("t4_crc", last_crc, 32'h55545352);

    // 5: runt, then a normal packet
    c0 = crc_pulses; r0 = runt_pulses; b0 = out_beats;
    send_pkt(3, 8'h80);
    wait_drain("t5a");
    chk("t5_runt_pulses", runt_pulses - r0, 1);
    chk("t5_no_crc", crc_pulses - c0, 0);
    chk("t5_no_beats", out_beats - b0, 0);
    send_pkt(9, 8'h90);
    wait_drain("t5b");
    chk("t5_keep", last_keep, 8'h1F);
    chk("t5_crc", last_crc, 32'h98979695);

    // back-to-back packets
    foreach (tbl[i]) send_pkt(tbl[i], 8'(8'hA0 + 8'(i * 16)));
    wait_drain("b2b");

    // 6: reset while draining TAIL
    i_m_tready = 1'b0;
    send_pkt(14, 8'h60);
    chk("t6_in_tail", o_state, 2'd2);
    chk("t6_pre_valid", o_m_tvalid, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    crc_q.delete();
    #1;
    chk("t6_rst_valid", o_m_tvalid, 1'b0);
    chk("t6_rst_state", o_state, 2'd0);
    chk("t6_rst_s_tready", o_s_tready, 1'b0);
    chk("t6_rst_crc", o_crc, '0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    i_m_tready = 1'b1;
    @(posedge clk);
    #1;
    c0 = crc_pulses; b0 = out_beats;
    send_pkt(8, 8'h00);
    wait_drain("t6");
    chk("t6_keep", last_keep, 8'h0F);
    chk("t6_data", last_data[31:0], 32'h03020100);
    chk("t6_crc", last_crc, 32'h07060504);
    chk("t6_crc_pulses", crc_pulses - c0, 1);
    chk("t6_beats", out_beats - b0, 1);

    chk("end_exp_q", exp_q.size(), 0);
    chk("end_crc_q", crc_q.size(), 0);
    chk("end_runt", runt_exp, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
